// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - 2-bit BHT + direct-mapped BTB fetch predictor with MEM-stage resolver
// Optional gshare history indexing of the BHT is enabled by defining BP_GSHARE_EN.
module branch_predictor #(
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] if_pc,
  output logic [DATA_WIDTH-1:0] if_pc_predict,
  output logic                  if_branch_predict,
  input  logic [DATA_WIDTH-1:0] mem_PC,
  input  logic [DATA_WIDTH-1:0] mem_pc_plus_4,
  input  logic [DATA_WIDTH-1:0] mem_pc_target,
  input  logic                  mem_branch,
  input  logic                  mem_taken,
  input  logic [1:0]            mem_jump,
  input  logic [DATA_WIDTH-1:0] mem_pc_predict,
  input  logic                  mem_branch_predict,
  output logic                  mispredict,
  output logic [DATA_WIDTH-1:0] redirect_pc
);

  localparam int ENTRIES = 1 << IDX_WIDTH;
  localparam int TAG_W   = DATA_WIDTH - IDX_WIDTH - 2;

  logic [ENTRIES-1:0][1:0] bht;
  logic [ENTRIES-1:0]      btb_valid;
  logic [TAG_W-1:0]        btb_tag    [ENTRIES];
  logic [DATA_WIDTH-1:0]   btb_target [ENTRIES];

  logic [IDX_WIDTH-1:0] if_idx, if_bht_idx, mem_idx, mem_bht_idx;
  logic [TAG_W-1:0]     if_tag, mem_tag;
  logic                 if_hit;
  logic                 train;
  logic [DATA_WIDTH-1:0] expected_pc;

  // Low PC bits are always word-aligned; the fetch-side taken bit is not needed to resolve.
  logic unused_bits;
  assign unused_bits = ^{if_pc[1:0], mem_PC[1:0], mem_branch_predict};

  assign if_idx  = if_pc[IDX_WIDTH+1:2];
  assign if_tag  = if_pc[DATA_WIDTH-1:IDX_WIDTH+2];
  assign mem_idx = mem_PC[IDX_WIDTH+1:2];
  assign mem_tag = mem_PC[DATA_WIDTH-1:IDX_WIDTH+2];

`ifdef BP_GSHARE_EN
  logic [IDX_WIDTH-1:0] ghr;

  assign if_bht_idx  = if_idx ^ ghr;
  assign mem_bht_idx = mem_idx ^ ghr;

  always_ff @(posedge clk) begin
    if (reset) begin
      ghr <= '0;
    end else if (train) begin
      ghr <= {ghr[IDX_WIDTH-2:0], mem_taken};
    end
  end
`else
  assign if_bht_idx  = if_idx;
  assign mem_bht_idx = mem_idx;
`endif

  assign if_hit            = btb_valid[if_idx] && (btb_tag[if_idx] == if_tag);
  assign if_branch_predict = if_hit && bht[if_bht_idx][1];
  assign if_pc_predict     = if_branch_predict ? btb_target[if_idx]
                                               : if_pc + DATA_WIDTH'(4);

  // A bubble presents all zeros, so predict == plus_4 and no redirect is raised.
  always_comb begin
    mispredict  = 1'b0;
    redirect_pc = '0;
    expected_pc = mem_pc_plus_4;
    if (mem_branch && mem_taken) begin
      expected_pc = mem_pc_target;
    end
    if (!reset && (mem_jump == 2'b00) && (mem_pc_predict != expected_pc)) begin
      mispredict  = 1'b1;
      redirect_pc = expected_pc;
    end
  end

  assign train = !reset && mem_branch && (mem_jump == 2'b00);

  always_ff @(posedge clk) begin
    if (reset) begin
      bht       <= {ENTRIES{2'b01}};
      btb_valid <= '0;
    end else if (train) begin
      if (mem_taken) begin
        if (bht[mem_bht_idx] != 2'b11) begin
          bht[mem_bht_idx] <= bht[mem_bht_idx] + 2'd1;
        end
        btb_valid[mem_idx] <= 1'b1;
      end else if (bht[mem_bht_idx] != 2'b00) begin
        bht[mem_bht_idx] <= bht[mem_bht_idx] - 2'd1;
      end
    end
  end

  // Tag/target need no reset: valid gates every use of them.
  always_ff @(posedge clk) begin
    if (train && mem_taken) begin
      btb_tag[mem_idx]    <= mem_tag;
      btb_target[mem_idx] <= mem_pc_target;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed self-checking bench for branch_predictor
// Expected values are hand-derived from the counter/BTB walk in the sequence below.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_pc;
  logic [31:0] if_pc_predict;
  logic        if_branch_predict;
  logic [31:0] mem_PC, mem_pc_plus_4, mem_pc_target, mem_pc_predict;
  logic        mem_branch, mem_taken, mem_branch_predict;
  logic [1:0]  mem_jump;
  logic        mispredict;
  logic [31:0] redirect_pc;

  int vectors = 0;
  int fails   = 0;

  branch_predictor #(.DATA_WIDTH(32), .IDX_WIDTH(4)) dut (
    .clk(clk), .reset(reset),
    .if_pc(if_pc), .if_pc_predict(if_pc_predict), .if_branch_predict(if_branch_predict),
    .mem_PC(mem_PC), .mem_pc_plus_4(mem_pc_plus_4), .mem_pc_target(mem_pc_target),
    .mem_branch(mem_branch), .mem_taken(mem_taken), .mem_jump(mem_jump),
    .mem_pc_predict(mem_pc_predict), .mem_branch_predict(mem_branch_predict),
    .mispredict(mispredict), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mem(input logic [31:0] pc, input logic br, input logic tk,
                         input logic [1:0] jmp, input logic [31:0] tgt, input logic [31:0] pred);
    mem_PC         = pc;
    mem_pc_plus_4  = (pc == 32'h0) ? 32'h0 : pc + 32'h4;
    mem_branch     = br;
    mem_taken      = tk;
    mem_jump       = jmp;
    mem_pc_target  = tgt;
    mem_pc_predict = pred;
    mem_branch_predict = (pred != mem_pc_plus_4);
    #1;
  endtask

  task automatic bubble();
    set_mem(32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
  endtask

  task automatic expect_fetch(input string tag, input logic [31:0] pc,
                              input logic taken, input logic [31:0] next);
    if_pc = pc;
    #1;
    check({tag, "_taken"}, {31'b0, if_branch_predict}, {31'b0, taken});
    check({tag, "_next"}, if_pc_predict, next);
  endtask

  initial begin
    reset = 1'b1;
    if_pc = 32'h100;
    set_mem(32'h100, 1'b1, 1'b1, 2'b00, 32'h40, 32'h104);
    check("reset_mispredict", {31'b0, mispredict}, 32'h0);
    check("reset_redirect", redirect_pc, 32'h0);
    step();
    reset = 1'b0;
    bubble();
    expect_fetch("post_reset", 32'h100, 1'b0, 32'h104);
    expect_fetch("pc_wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);
    check("bubble_mispredict", {31'b0, mispredict}, 32'h0);
    check("bubble_redirect", redirect_pc, 32'h0);

    // First taken resolution: counter 01 -> 10, BTB filled.
    set_mem(32'h100, 1'b1, 1'b1, 2'b00, 32'h40, 32'h104);
    check("first_taken_mispredict", {31'b0, mispredict}, 32'h1);
    check("first_taken_redirect", redirect_pc, 32'h40);
    step();
    bubble();
    expect_fetch("after_first_taken", 32'h100, 1'b1, 32'h40);

    // Predicted taken, resolves not-taken: 10 -> 01.
    set_mem(32'h100, 1'b1, 1'b0, 2'b00, 32'h40, 32'h40);
    check("nt_mispredict", {31'b0, mispredict}, 32'h1);
    check("nt_redirect", redirect_pc, 32'h104);
    step();
    bubble();
    expect_fetch("after_nt", 32'h100, 1'b0, 32'h104);

    // Four taken: 10, 11, 11, 11.
    set_mem(32'h100, 1'b1, 1'b1, 2'b00, 32'h40, 32'h40);
    check("correct_taken_mispredict", {31'b0, mispredict}, 32'h0);
    check("correct_taken_redirect", redirect_pc, 32'h0);
    for (int i = 0; i < 4; i++) step();
    bubble();
    expect_fetch("sat_high", 32'h100, 1'b1, 32'h40);

    // One not-taken from 11 leaves 10 and the BTB entry intact.
    set_mem(32'h100, 1'b1, 1'b0, 2'b00, 32'h40, 32'h40);
    step();
    bubble();
    expect_fetch("sat_high_minus1", 32'h100, 1'b1, 32'h40);

    // Four more not-taken: 01, 00, 00, 00; then taken twice: 01, 10.
    set_mem(32'h100, 1'b1, 1'b0, 2'b00, 32'h40, 32'h104);
    check("correct_nt_mispredict", {31'b0, mispredict}, 32'h0);
    for (int i = 0; i < 4; i++) step();
    bubble();
    expect_fetch("sat_low", 32'h100, 1'b0, 32'h104);
    set_mem(32'h100, 1'b1, 1'b1, 2'b00, 32'h40, 32'h104);
    step();
    bubble();
    expect_fetch("sat_low_plus1", 32'h100, 1'b0, 32'h104);
    set_mem(32'h100, 1'b1, 1'b1, 2'b00, 32'h40, 32'h104);
    step();
    bubble();
    expect_fetch("sat_low_plus2", 32'h100, 1'b1, 32'h40);

    // Aliasing: 0x140 shares idx 0 with 0x100 but has a different tag.
    expect_fetch("alias_miss", 32'h140, 1'b0, 32'h144);

    // Jump in MEM: never checked, never trains, even with branch/taken set.
    set_mem(32'h140, 1'b1, 1'b1, 2'b01, 32'h80, 32'h999);
    check("jal_mispredict", {31'b0, mispredict}, 32'h0);
    check("jal_redirect", redirect_pc, 32'h0);
    step();
    bubble();
    expect_fetch("jal_no_train_alias", 32'h140, 1'b0, 32'h144);
    expect_fetch("jal_no_train_orig", 32'h100, 1'b1, 32'h40);

    // Stale hit on a non-branch redirects to fall-through and does not train.
    set_mem(32'h100, 1'b0, 1'b0, 2'b00, 32'h0, 32'h40);
    check("nonbranch_mispredict", {31'b0, mispredict}, 32'h1);
    check("nonbranch_redirect", redirect_pc, 32'h104);
    step();
    bubble();
    expect_fetch("nonbranch_no_train", 32'h100, 1'b1, 32'h40);

    // Same-idx read during update sees the old counter (10), then 01.
    set_mem(32'h100, 1'b1, 1'b0, 2'b00, 32'h40, 32'h40);
    expect_fetch("rw_same_cycle", 32'h100, 1'b1, 32'h40);
    step();
    bubble();
    expect_fetch("rw_next_cycle", 32'h100, 1'b0, 32'h104);

    // Reset wins over a concurrent taken training event.
    reset = 1'b1;
    set_mem(32'h100, 1'b1, 1'b1, 2'b00, 32'h40, 32'h104);
    check("reset_train_mispredict", {31'b0, mispredict}, 32'h0);
    check("reset_train_redirect", redirect_pc, 32'h0);
    step();
    reset = 1'b0;
    bubble();
    expect_fetch("reset_train_blocked", 32'h100, 1'b0, 32'h104);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #20000;
    fails++;
    $display("FAIL timeout: simulation did not reach end of sequence");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side branch predictor and MEM-side resolver for the 5-stage pipeline.
- At IF it produces the predicted next PC and the predicted-taken bit. These travel down the pipe and reach the EX/MEM register as pc_predict / branch_predict.
- At MEM it consumes the resolved branch outcome from the EX/MEM register. It trains a 2-bit BHT and a direct-mapped BTB, and raises mispredict with the correct redirect PC.

Parameters:
- DATA_WIDTH, 32, PC/target width.
- IDX_WIDTH, 4, table index bits; BHT and BTB each hold 2**IDX_WIDTH entries.

Ports:
- clk  in  1  clock, all state updates on posedge.
- reset  in  1  synchronous, active-high.
- if_pc  in  DATA_WIDTH  PC of the instruction being fetched.
- if_pc_predict  out  DATA_WIDTH  predicted next fetch PC.
- if_branch_predict  out  1  predicted taken (BTB hit and BHT counter[1]).
- mem_PC  in  DATA_WIDTH  PC of the instruction in MEM.
- mem_pc_plus_4  in  DATA_WIDTH  fall-through PC of the MEM instruction.
- mem_pc_target  in  DATA_WIDTH  resolved branch target.
- mem_branch  in  1  MEM instruction is a conditional branch.
- mem_taken  in  1  resolved branch outcome.
- mem_jump  in  2  nonzero means JAL/JALR; excluded from checking and training.
- mem_pc_predict  in  DATA_WIDTH  next PC predicted at fetch for this instruction.
- mem_branch_predict  in  1  taken prediction made at fetch.
- mispredict  out  1  MEM-stage redirect request; the pipeline flushes IF/ID, ID/EX and EX/MEM.
- redirect_pc  out  DATA_WIDTH  correct next PC when mispredict=1, else 0.

Behaviour:
- Index fields:
  - idx = pc[IDX_WIDTH+1:2].
  - tag = pc[DATA_WIDTH-1:IDX_WIDTH+2].
- Storage:
  - BHT: 2**IDX_WIDTH 2-bit saturating counters.
  - BTB: valid, tag, target per entry.
- Reset (synchronous, one posedge with reset=1):
  - all BHT counters = 2'b01 (weakly not-taken).
  - all BTB valid = 0.
  - mispredict and redirect_pc are forced to 0 while reset=1.
  - With all entries invalid: if_branch_predict = 0 and if_pc_predict = if_pc+4.
- Prediction (combinational, zero latency):
  - hit = valid[idx] && tag match.
  - if_branch_predict = hit && bht[idx][1].
  - if_pc_predict = if_branch_predict ? btb_target[idx] : if_pc + 4, modulo 2**DATA_WIDTH.
- Resolution (combinational from MEM inputs), when mem_jump==0:
  - Branch (mem_branch=1): expected = mem_taken ? mem_pc_target : mem_pc_plus_4. mispredict = (mem_pc_predict != expected).
  - Non-branch (mem_branch=0): mispredict = (mem_pc_predict != mem_pc_plus_4). Covers stale or aliased BTB hits.
  - When mispredict=1: redirect_pc = expected for a branch, mem_pc_plus_4 for a non-branch.
  - Flushed bubble (all-zero EX/MEM contents) compares 0 == 0, so mispredict = 0.
- Training (posedge, only when reset=0, mem_branch=1 and mem_jump==0):
  - Counter at idx(mem_PC): +1 if mem_taken, -1 otherwise, saturating at 2'b11 and 2'b00.
  - If mem_taken: BTB[idx] gets valid=1, tag(mem_PC), target=mem_pc_target. Overwrites any other tag.
  - Not-taken never invalidates a BTB entry.
- Simultaneous read and write of the same idx: the IF read sees the pre-update value; the update is visible from the next cycle.
- reset=1 concurrent with a training condition: reset wins, no update.
- Single update port, one resolution per cycle; no stall input is needed because the EX/MEM register only holds a valid instruction or a bubble.

Optional Feature:
- Macro: BP_GSHARE_EN.
- Defined:
  - Adds an IDX_WIDTH-bit global history register, reset to 0.
  - BHT index for both prediction and training = idx XOR ghr.
  - Each training event shifts mem_taken into ghr bit 0, at the same posedge as the counter update.
  - Prediction and training both use the current ghr value.
  - BTB indexing is unchanged.
- Undefined: no history register; the BHT is indexed by idx only.

Test Plan:
- Reset, then if_pc=0x100 → if_branch_predict=0, if_pc_predict=0x104. Bubble in MEM (all zeros) → mispredict=0.
- First taken branch: mem_PC=0x100, mem_branch=1, mem_taken=1, mem_pc_target=0x40, mem_pc_predict=0x104 → mispredict=1, redirect_pc=0x40. Next cycle if_pc=0x100 → counter=2'b10, if_pc_predict=0x40, if_branch_predict=1.
- Predicted-taken branch resolves not-taken: mem_pc_predict=0x40, mem_taken=0, mem_pc_plus_4=0x104 → mispredict=1, redirect_pc=0x104. Counter 2'b10→2'b01, BTB entry stays valid.
- Four consecutive taken resolutions at 0x100 → counter saturates at 2'b11. Five not-taken resolutions → 2'b00, no wrap.
- Aliasing: train 0x100 taken, then if_pc=0x140 (same idx, different tag) → no hit, if_pc_predict=0x144. A JAL in MEM with a wrong mem_pc_predict → mispredict=0, no table change.
- Assert reset while a training branch is in MEM → no update, mispredict=0. After reset, 0x100 predicts 0x104.
- BP_GSHARE_EN defined: after a taken resolution, ghr=1 and the same PC indexes idx^1.
